// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Staged reset release for memory, peripheral and core domains.
//                Waits for clock lock, then releases each domain STAGE_DELAY
//                cycles apart. Lock loss, a software request or (optionally)
//                a watchdog timeout re-asserts every domain reset and records
//                the cause.
//                Optional watchdog: define KABETA_RESET_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module reset_sequencer #(
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned SW_HOLD     = 8,
    parameter int unsigned WDT_TIMEOUT = 1048576
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PllLocked,
    input  logic       SwResetReq,
    input  logic       WdtKick,
    output logic       MemReset,
    output logic       PeriphReset,
    output logic       CoreReset,
    output logic       ResetDone,
    output logic [1:0] ResetCause
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        REL_MEM    = 3'd1,
        REL_PERIPH = 3'd2,
        REL_CORE   = 3'd3,
        RUN        = 3'd4,
        SW_HOLD_ST = 3'd5
    } state_t;

    localparam logic [15:0] c_STAGE_LAST = 16'(STAGE_DELAY - 1);
    localparam logic [15:0] c_HOLD_LAST  = 16'(SW_HOLD - 1);

    localparam logic [1:0] c_CAUSE_POR  = 2'b00;
    localparam logic [1:0] c_CAUSE_SW   = 2'b01;
    localparam logic [1:0] c_CAUSE_LOCK = 2'b10;
    localparam logic [1:0] c_CAUSE_WDT  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_cause;
    logic [1:0]  w_cause_nxt;
    logic        r_mem_rst;
    logic        r_per_rst;
    logic        r_core_rst;
    logic        r_done;
    logic        w_mem_nxt;
    logic        w_per_nxt;
    logic        w_core_nxt;
    logic        w_done_nxt;
    logic        w_lock_loss;
    logic        w_wdt_fire;

`ifdef KABETA_RESET_WATCHDOG_EN
    localparam logic [31:0] c_WDT_LAST = 32'(WDT_TIMEOUT - 1);

    logic [31:0] r_wdt;

    assign w_wdt_fire = (r_state == RUN) && !WdtKick && (r_wdt == c_WDT_LAST);

    // Watchdog counter: runs only while staying in RUN, a kick clears it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wdt <= 32'd0;
        end else if ((r_state != RUN) || (w_state_nxt != RUN) || WdtKick) begin
            r_wdt <= 32'd0;
        end else begin
            r_wdt <= r_wdt + 32'd1;
        end
    end
`else
    logic w_unused_wdt;

    assign w_wdt_fire   = 1'b0;
    assign w_unused_wdt = WdtKick & (WDT_TIMEOUT != 0);
`endif

    // Lock loss is only meaningful once a release sequence has started
    assign w_lock_loss = (r_state != WAIT_LOCK) && !PllLocked;

    // Next-state, counter and cause selection; lock loss beats watchdog beats SW
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_cause_nxt = r_cause;
        if (w_lock_loss) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = 16'd0;
            if (r_state == RUN) begin
                w_cause_nxt = c_CAUSE_LOCK;
            end
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_cnt_nxt = 16'd0;
                    if (PllLocked) begin
                        w_state_nxt = REL_MEM;
                    end
                end
                REL_MEM: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_state_nxt = REL_PERIPH;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                REL_PERIPH: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_state_nxt = REL_CORE;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                REL_CORE: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                RUN: begin
                    w_cnt_nxt = 16'd0;
                    if (w_wdt_fire) begin
                        w_state_nxt = SW_HOLD_ST;
                        w_cause_nxt = c_CAUSE_WDT;
                    end else if (SwResetReq) begin
                        w_state_nxt = SW_HOLD_ST;
                        w_cause_nxt = c_CAUSE_SW;
                    end
                end
                SW_HOLD_ST: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Domain resets are a decode of the next state so they change on the
    // same edge as the state transition while still coming from flops
    always_comb begin
        w_mem_nxt  = 1'b1;
        w_per_nxt  = 1'b1;
        w_core_nxt = 1'b1;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            REL_PERIPH: begin
                w_mem_nxt = 1'b0;
            end
            REL_CORE: begin
                w_mem_nxt = 1'b0;
                w_per_nxt = 1'b0;
            end
            RUN: begin
                w_mem_nxt  = 1'b0;
                w_per_nxt  = 1'b0;
                w_core_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_mem_nxt = 1'b1;
            end
        endcase
    end

    // State, stage counter and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= 16'd0;
            r_cause    <= c_CAUSE_POR;
            r_mem_rst  <= 1'b1;
            r_per_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cause    <= w_cause_nxt;
            r_mem_rst  <= w_mem_nxt;
            r_per_rst  <= w_per_nxt;
            r_core_rst <= w_core_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign MemReset    = r_mem_rst;
    assign PeriphReset = r_per_rst;
    assign CoreReset   = r_core_rst;
    assign ResetDone   = r_done;
    assign ResetCause  = r_cause;

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGE_DELAY, default 16: cycles each release stage lasts (legal range 2..65535).
REQ-002 SHALL have parameter SW_HOLD, default 8: cycles all domain resets stay asserted after a software or watchdog reset (legal range 1..65535).
REQ-003 SHALL have parameter WDT_TIMEOUT, default 1048576: watchdog timeout in cycles; used only when WATCHDOG_EN is defined.
REQ-004 SHALL have port Clock  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous assert, active-high; must already be released synchronously to Clock.
REQ-006 SHALL have port PllLocked  input  1  clock-source lock status, high = locked.
REQ-007 SHALL have port SwResetReq  input  1  software reset request, sampled on each rising edge.
REQ-008 SHALL have port WdtKick  input  1  watchdog service pulse.
REQ-009 SHALL have port MemReset  output  1  memory-domain reset, active-high.
REQ-010 SHALL have port PeriphReset  output  1  peripheral-domain reset, active-high.
REQ-011 SHALL have port CoreReset  output  1  CPU-core reset, active-high.
REQ-012 SHALL have port ResetDone  output  1  high only while all domains are released.
REQ-013 SHALL have port ResetCause  output  2  cause of the last reset: 00 POR, 01 SW, 10 LOCK_LOSS, 11 WDT.

Function
REQ-014 SHALL implement the states WAIT_LOCK, REL_MEM, REL_PERIPH, REL_CORE, RUN and SW_HOLD_ST, using one stage counter of at least 16 bits.
REQ-015 SHALL drive every output from a register; no output SHALL depend combinationally on any input.
REQ-016 SHALL move from WAIT_LOCK to REL_MEM on the first edge that samples PllLocked=1, and SHALL clear the counter on that edge.
REQ-017 SHALL stay in each of REL_MEM, REL_PERIPH and REL_CORE for exactly STAGE_DELAY cycles, then advance to the next state and clear the counter.
REQ-018 SHALL deassert MemReset on entry to REL_PERIPH, PeriphReset on entry to REL_CORE, and CoreReset together with ResetDone on entry to RUN.
REQ-019 SHALL produce these edge timings when PllLocked is first sampled high at edge E: MemReset falls at E+D, PeriphReset at E+2D, CoreReset and ResetDone at E+3D, where D = STAGE_DELAY.
REQ-020 SHALL, in any state other than WAIT_LOCK, respond to a sample of PllLocked=0 by asserting all three resets, clearing ResetDone, clearing the counter and entering WAIT_LOCK on the same edge.
REQ-021 SHALL set ResetCause=10 when that lock loss (REQ-020) happens in RUN; lock loss during a release stage SHALL leave ResetCause unchanged.
REQ-022 SHALL, in RUN, respond to a sample of SwResetReq=1 by asserting all resets, clearing ResetDone, setting ResetCause=01 and entering SW_HOLD_ST.
REQ-023 SHALL ignore SwResetReq in every state other than RUN.
REQ-024 SHALL stay in SW_HOLD_ST for SW_HOLD cycles and then enter WAIT_LOCK, from which the full release sequence repeats.
REQ-025 SHALL apply this priority when events occur on the same edge: lock loss, then watchdog timeout, then SwResetReq.
REQ-026 SHALL hold ResetCause constant except on the transitions named in REQ-021, REQ-022 and REQ-030.

Reset
REQ-027 SHALL, while Reset=1 and independently of Clock, force: state WAIT_LOCK, counter 0, MemReset=1, PeriphReset=1, CoreReset=1, ResetDone=0, ResetCause=00, watchdog counter 0.
REQ-028 SHALL begin normal operation on the first rising edge of Clock after Reset falls.

Configuration
REQ-029 SHALL compile the watchdog in only when the macro KABETA_RESET_WATCHDOG_EN is defined.
REQ-030 SHALL, with the macro defined, run the watchdog counter only in RUN:
- a sample of WdtKick=1 sets it to 0;
- otherwise it increments by one each cycle;
- reaching WDT_TIMEOUT-1 without a kick causes the REQ-022 behaviour with ResetCause=11;
- the counter is held at 0 outside RUN.
REQ-031 SHALL, without the macro, have no watchdog logic, ignore WdtKick, and never set ResetCause=11.

Verification
REQ-032 SHALL cover the power-on case (D=4): Reset released, PllLocked high at edge E -> MemReset falls at E+4, PeriphReset at E+8, CoreReset and ResetDone at E+12, ResetCause=00.
REQ-033 SHALL cover the software reset case (SW_HOLD=3): in RUN, SwResetReq pulsed for 1 cycle -> all resets high on the next edge, ResetCause=01, 3 cycles in SW_HOLD_ST, then the REQ-032 sequence repeats.
REQ-034 SHALL cover lock loss in two cases: PllLocked dropped in REL_PERIPH -> MemReset reasserts on the next edge and ResetCause is unchanged; PllLocked dropped in RUN -> ResetCause=10.
REQ-035 SHALL cover the watchdog (macro defined, WDT_TIMEOUT=10): no kicks in RUN -> reset after 10 cycles with ResetCause=11; a kick every 5 cycles -> ResetDone stays high.
REQ-036 SHALL cover simultaneous events and mid-sequence reset: SwResetReq and PllLocked=0 on the same edge -> ResetCause=10; Reset asserted mid-REL_CORE -> all outputs take reset values immediately, with no clock edge required.
